// File: rtl/sat_accumulator_if.sv
// Handshake bundle for sat_accumulator: operand beats in, group results out.
// The master modport is the upstream/downstream pair, the slave modport is the accumulator.
interface sat_accumulator_if #(
  parameter int P     = 8,
  parameter int ACC_W = 12,
  parameter int LANES = 4
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [LANES*P-1:0]     in_data_i;
  logic                   in_last_i;
  logic                   sat_en_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [LANES*ACC_W-1:0] out_data_o;
  logic [LANES-1:0]       out_ovf_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    output in_last_i,
    output sat_en_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_ovf_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  in_last_i,
    input  sat_en_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_ovf_o
  );
endinterface

// File: rtl/sat_accumulator.sv
// Multi-lane signed group accumulator with per-group saturate/wrap mode.
// Results are held with sticky per-lane overflow flags until handed off.
module sat_accumulator #(
  parameter int P     = 8,
  parameter int ACC_W = 12,
  parameter int LANES = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  sat_accumulator_if.slave  bus
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]                  state_q, state_d;
  logic                        first_q, first_d;
  logic                        mode_q, mode_d;
  logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]            ovf_q, ovf_d;

  logic                        in_fire;
  logic                        out_fire;
  logic                        open_grp;
  logic                        mode_eff;
  logic [LANES-1:0][ACC_W-1:0] acc_nxt;
  logic [LANES-1:0]            ovf_lane;

  assign bus.out_valid_o = (state_q == HOLD);
  assign bus.in_ready_o  = (state_q == ACCUM) | bus.out_ready_i;
  assign bus.out_data_o  = acc_q;
  assign bus.out_ovf_o   = ovf_q;

  assign in_fire  = bus.in_valid_i & bus.in_ready_o;
  assign out_fire = bus.out_valid_o & bus.out_ready_i;

  // A beat accepted alongside the result handshake opens the next group.
  assign open_grp = first_q | out_fire;
  assign mode_eff = open_grp ? bus.sat_en_i : mode_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [P-1:0]   x;
    logic [ACC_W:0] x_ext;
    logic [ACC_W:0] base;
    logic [ACC_W:0] sum;

    assign x     = bus.in_data_i[k*P +: P];
    assign x_ext = {{(ACC_W+1-P){x[P-1]}}, x};
    assign base  = open_grp ? '0
                            : {acc_q[k][ACC_W-1], acc_q[k]};
    assign sum   = base + x_ext;

    assign ovf_lane[k] = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
      acc_nxt[k] = sum[ACC_W-1:0];
      if (ovf_lane[k] && mode_eff)
        acc_nxt[k] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (out_fire) begin
      state_d = ACCUM;
      first_d = 1'b1;
    end

    if (in_fire) begin
      first_d = 1'b0;
      mode_d  = mode_eff;
      acc_d   = acc_nxt;
      ovf_d   = (open_grp ? '0 : ovf_q) | ovf_lane;
      state_d = bus.in_last_i ? HOLD : ACCUM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      first_q <= 1'b1;
      mode_q  <= 1'b1;
      acc_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: per-cycle vector table plus
// hand-written multi-beat group sequences.
module tb_sat_accumulator;

  localparam int P     = 8;
  localparam int ACC_W = 12;
  localparam int LANES = 4;

  logic clk;
  logic rst_n;

  sat_accumulator_if #(.P(P), .ACC_W(ACC_W), .LANES(LANES)) bus ();

  sat_accumulator #(.P(P), .ACC_W(ACC_W), .LANES(LANES)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] din;
    logic        last;
    logic        sat;
    logic        oready;
    logic        e_valid;
    logic        e_iready;
    logic        chk_d;
    logic [47:0] e_data;
    logic [3:0]  e_ovf;
  } vec_t;

  function automatic logic [31:0] pk8(int a, int b, int c, int d);
    logic [31:0] r;
    r = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return r;
  endfunction

  function automatic logic [47:0] pk12(int a, int b, int c, int d);
    logic [47:0] r;
    r = {d[11:0], c[11:0], b[11:0], a[11:0]};
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(int a, int b, int c, int d,
                           logic last, logic sat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready_o) begin
      errors++;
      $display("FAIL beat_wait: in_ready stuck at 0, expected 1");
    end
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = pk8(a, b, c, d);
    bus.in_last_i  = last;
    bus.sat_en_i   = sat;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic expect_result(string name, logic [47:0] ed,
                               logic [3:0] eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 64'(bus.out_valid_o), 64'(1));
    chk({name, "_data"}, 64'(bus.out_data_o), 64'(ed));
    chk({name, "_ovf"}, 64'(bus.out_ovf_o), 64'(eo));
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    logic [47:0] r1;
    logic [47:0] r5;
    r1 = pk12(0, 1, -8, 127);
    r5 = pk12(5, 5, 5, 5);

    // valid din last sat ordy | e_valid e_iready chk_d e_data e_ovf
    tbl[0]  = '{0, 32'h0, 0, 1, 1, 0, 1, 1, 48'h0, 4'h0};
    tbl[1]  = '{1, pk8(0, 1, -8, 127), 1, 1, 1, 0, 1, 0, 48'h0, 4'h0};
    tbl[2]  = '{0, 32'h0, 0, 1, 0, 1, 0, 1, r1, 4'h0};
    tbl[3]  = '{0, 32'h0, 0, 1, 0, 1, 0, 1, r1, 4'h0};
    tbl[4]  = '{1, pk8(9, 9, 9, 9), 1, 1, 0, 1, 0, 1, r1, 4'h0};
    tbl[5]  = '{0, 32'h0, 0, 1, 0, 1, 0, 1, r1, 4'h0};
    tbl[6]  = '{0, 32'h0, 0, 1, 0, 1, 0, 1, r1, 4'h0};
    tbl[7]  = '{1, pk8(5, 5, 5, 5), 1, 1, 1, 1, 1, 1, r1, 4'h0};
    tbl[8]  = '{0, 32'h0, 0, 1, 0, 1, 0, 1, r5, 4'h0};
    tbl[9]  = '{0, 32'h0, 0, 1, 1, 1, 1, 1, r5, 4'h0};
    tbl[10] = '{0, 32'h0, 0, 1, 1, 0, 1, 0, 48'h0, 4'h0};

    rst_n          = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.in_last_i   = 1'b0;
    bus.sat_en_i    = 1'b1;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.in_valid_i  = tbl[i].valid;
      bus.in_data_i   = tbl[i].din;
      bus.in_last_i   = tbl[i].last;
      bus.sat_en_i    = tbl[i].sat;
      bus.out_ready_i = tbl[i].oready;
      #1;
      chk($sformatf("row%0d_valid", i),
          64'(bus.out_valid_o), 64'(tbl[i].e_valid));
      chk($sformatf("row%0d_iready", i),
          64'(bus.in_ready_o), 64'(tbl[i].e_iready));
      if (tbl[i].chk_d) begin
        chk($sformatf("row%0d_data", i),
            64'(bus.out_data_o), 64'(tbl[i].e_data));
        chk($sformatf("row%0d_ovf", i),
            64'(bus.out_ovf_o), 64'(tbl[i].e_ovf));
      end
    end
    @(negedge clk);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;

    // Saturate mode over 20 beats
    for (int b = 1; b <= 20; b++)
      send_beat(127, -128, 1, 1, b == 20, 1'b1);
    expect_result("sat", pk12(2047, -2048, 20, 20), 4'b0011);

    // Wrap mode, same stimulus
    for (int b = 1; b <= 20; b++)
      send_beat(127, -128, 1, 1, b == 20, 1'b0);
    expect_result("wrap", pk12(-1556, 1536, 20, 20), 4'b0011);

    // Continue accumulating from a clamped value
    for (int b = 1; b <= 17; b++)
      send_beat(127, 0, 0, 0, 1'b0, 1'b1);
    send_beat(-10, 0, 0, 0, 1'b1, 1'b1);
    expect_result("clamp_cont", pk12(2037, 0, 0, 0), 4'b0001);

    // Mode sampled on first beat only
    for (int b = 1; b <= 20; b++)
      send_beat(127, -128, 1, 1, b == 20, b == 1);
    expect_result("mode_samp", pk12(2047, -2048, 20, 20), 4'b0011);

    // Wrap mode group opened after a saturating one
    send_beat(100, -100, 3, -3, 1'b1, 1'b0);
    expect_result("single2", pk12(100, -100, 3, -3), 4'b0000);

    // Reset mid-group discards the partial sum
    for (int b = 1; b <= 3; b++)
      send_beat(100, 100, 100, 100, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rst_iready", 64'(bus.in_ready_o), 64'(1));
    chk("rst_data", 64'(bus.out_data_o), 64'(0));
    chk("rst_ovf", 64'(bus.out_ovf_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(7, 7, 7, 7, 1'b1, 1'b1);
    expect_result("post_rst", pk12(7, 7, 7, 7), 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
